// File: rtl/vector_permute_pipe.sv
// Per-word bit/group permuter feeding a 2-entry {data, mode} output FIFO; 1-cycle latency, 1 word/cycle.
// Backpressure: in_ready is decoded from registered occupancy only and drops while both entries are full.
module vector_permute_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int NG = (GROUP >= 1) ? (WIDTH / GROUP) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("vector_permute_pipe: WIDTH must be >= 2");
    end
    if (GROUP < 1) begin : g_bad_group
      $error("vector_permute_pipe: GROUP must be >= 1");
    end else if ((WIDTH % GROUP) != 0) begin : g_bad_ratio
      $error("vector_permute_pipe: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] perm_rev, perm_grp, perm_ing, perm_dat;
  entry_t           new_entry;
  logic             accept, pop;

  // All four permutations are built in parallel; the mode only steers the final mux.
  always_comb begin
    perm_rev = '0;
    perm_grp = '0;
    perm_ing = '0;
    for (int i = 0; i < WIDTH; i++) begin
      perm_rev[WIDTH-1-i] = in_data[i];
    end
    for (int g = 0; g < NG; g++) begin
      for (int j = 0; j < GROUP; j++) begin
        perm_grp[(NG-1-g)*GROUP+j]   = in_data[g*GROUP+j];
        perm_ing[g*GROUP+GROUP-1-j]  = in_data[g*GROUP+j];
      end
    end
    perm_dat = in_data;
    case (in_mode)
      2'd1:    perm_dat = perm_rev;
      2'd2:    perm_dat = perm_grp;
      2'd3:    perm_dat = perm_ing;
      default: perm_dat = in_data;
    endcase
  end

  assign new_entry = '{mode: in_mode, data: perm_dat};

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        // A simultaneous pop retires the head, so the incoming word takes its place.
        if (accept && pop) begin
          head_d = new_entry;
        end else if (accept) begin
          tail_d  = new_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign cnt_d = cnt_q + CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data   = head_q.data;
  assign out_mode   = head_q.mode;
  assign xfer_count = cnt_q;

endmodule
